// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for a DIGITS-wide seven-segment hex display.
//   A free-running prescaler divides each digit slot into SCAN_DIV cycles.
//   The first GUARD cycles of every slot keep all anodes dark to suppress
//   ghosting. New values are loaded into a back buffer and copied to the
//   front buffer only at a frame boundary, so a frame never tears.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   num      : DIGITS hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp       : decimal point request per digit
//   load     : capture num/dp into the back buffer this cycle
//   blank_lz : blank leading zero digits (sampled live, not buffered)
//   seg      : segments {g,f,e,d,c,b,a}, registered
//   dp_out   : decimal point segment, registered
//   an       : digit enables, one-hot when active, registered
//   frame    : one-cycle pulse in the cycle after the front buffer updates
//
// Load/commit handshake: load has no ready; every cycle with load=1 is
// accepted into the back buffer and marks it pending. The pending contents
// are committed on the edge where the digit index wraps DIGITS-1 -> 0. A load
// on that same edge is committed directly and leaves nothing pending.
module seven_segment_scanner #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int             IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic           INV       = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GUARD_END = CW'(GUARD);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    back_num;
  logic [DIGITS-1:0]      back_dp;
  logic [4*DIGITS-1:0]    front_num;
  logic [DIGITS-1:0]      front_dp;
  logic                   pending;

  logic                   wrap;
  logic                   frame_end;
  logic                   commit;
  logic [DIGITS-1:0]      lead_zero;
  logic                   run;
  logic                   blank;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic [6:0]             seg_next;
  logic                   dp_next;
  logic [DIGITS-1:0]      an_next;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wrap      = (cnt == CNT_LAST);
  assign frame_end = wrap && (idx == IDX_LAST);
  assign commit    = frame_end && (pending || load);

  always_comb begin
    cur_nib   = front_num[4*idx +: 4];
    cur_dp    = front_dp[idx];
    // lead_zero[i] is set when digit i and every digit to its left carry
    // a zero nibble and no decimal point.
    run       = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run & (front_num[4*i +: 4] == 4'd0) & ~front_dp[i];
      lead_zero[i] = run;
    end
    blank    = blank_lz && (idx != '0) && lead_zero[idx];
    seg_next = (blank ? 7'd0 : hex_to_seg(cur_nib)) ^ {7{INV}};
    dp_next  = (~blank & cur_dp) ^ INV;
    an_next  = ((cnt < GUARD_END) ? {DIGITS{1'b0}} : (DIGITS'(1) << idx))
               ^ {DIGITS{INV}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      back_num  <= '0;
      back_dp   <= '0;
      front_num <= '0;
      front_dp  <= '0;
      pending   <= 1'b0;
      seg       <= {7{INV}};
      dp_out    <= INV;
      an        <= {DIGITS{INV}};
      frame     <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (load) begin
        back_num <= num;
        back_dp  <= dp;
      end
      if (commit) begin
        // A load on the commit edge bypasses the back buffer.
        front_num <= load ? num : back_num;
        front_dp  <= load ? dp  : back_dp;
      end
      pending <= commit ? 1'b0 : (pending | load);
      frame   <= commit;
      seg     <= seg_next;
      dp_out  <= dp_next;
      an      <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int FRAME_LEN = DIGITS * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [4*DIGITS-1:0] num = '0;
  logic [DIGITS-1:0]   dp = '0;
  logic                load = 1'b0;
  logic                blank_lz = 1'b0;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an;
  logic                frame;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .dp(dp), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp_out(dp_out), .an(an), .frame(frame)
  );

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp_out;
    logic              frame;
    logic              lit_valid;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  // Lit segments by letter, a..g.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] m;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
    endcase
    m = '0;
    for (int i = 0; i < s.len(); i++) m = m | (7'd1 << (s[i] - 8'd97));
    return m;
  endfunction

  int unsigned         k_count = 0;
  logic [4*DIGITS-1:0] m_front_num = '0, m_new_num = '0;
  logic [DIGITS-1:0]   m_front_dp = '0, m_new_dp = '0;
  bit                  m_has_new = 0;

  always @(posedge clk) begin
    int pos, digit;
    bit boundary, blanked;
    logic [DIGITS-1:0] an_hi;
    exp_t e;
    if (!rst_n) begin
      k_count     = 0;
      m_front_num = '0;
      m_front_dp  = '0;
      m_has_new   = 0;
    end else begin
      pos      = k_count % SCAN_DIV;
      digit    = (k_count / SCAN_DIV) % DIGITS;
      boundary = (k_count % FRAME_LEN) == FRAME_LEN - 1;
      blanked  = blank_lz && digit > 0 && ((m_front_num >> (4*digit)) == 0)
                 && ((m_front_dp >> digit) == 0);
      an_hi       = (pos >= GUARD) ? (DIGITS'(1) << digit) : '0;
      e.lit_valid = (pos >= GUARD);
      e.an        = ~an_hi;
      e.seg       = ~(blanked ? 7'd0 : glyph(m_front_num[4*digit +: 4]));
      e.dp_out    = ~(!blanked && m_front_dp[digit]);
      e.frame     = boundary && (m_has_new || load);
      exp_q.push_back(e);
      if (load) begin
        m_new_num = num;
        m_new_dp  = dp;
        m_has_new = 1;
      end
      if (boundary && m_has_new) begin
        m_front_num = m_new_num;
        m_front_dp  = m_new_dp;
        m_has_new   = 0;
      end
      k_count++;
    end
  end

  // ---------------- monitor ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an, {DIGITS{1'b1}});
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp_out"}, dp_out, 1'b1);
    check({tag, "_frame"}, frame, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check_reset_outputs("reset_hold");
      end else if (exp_q.size() == 0) begin
        check("exp_queue_nonempty", 0, 1);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("an", an, e.an);
        check("frame", frame, e.frame);
        if (e.lit_valid) begin
          check("seg", seg, e.seg);
          check("dp_out", dp_out, e.dp_out);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    bit reached = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if ((k_count % FRAME_LEN) == ph) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    check("phase_reached", reached, 1);
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d);
    num  = v;
    dp   = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    num  = 16'($urandom);
    dp   = 4'($urandom);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    pulse_reset(2);
    idle(40);

    wait_phase(12);
    do_load(16'h12AF, 4'b0000);
    idle(80);

    blank_lz = 1'b1;
    wait_phase(5);
    do_load(16'h0050, 4'b0000);
    idle(70);
    wait_phase(5);
    do_load(16'h0050, 4'b1000);
    idle(70);

    blank_lz = 1'b0;
    wait_phase(FRAME_LEN - 1);
    do_load(16'h0003, 4'b0000);
    idle(40);

    wait_phase(2);
    do_load(16'h1111, 4'b0000);
    wait_phase(10);
    do_load(16'h2222, 4'b0000);
    idle(70);

    wait_phase(5);
    do_load(16'h9876, 4'b0101);
    wait_phase(14);
    pulse_reset(1);
    idle(70);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        // Bias toward zero-heavy values so leading-zero blanking is exercised.
        do_load(16'($urandom) & 16'($urandom) & 16'($urandom), 4'($urandom_range(0, 15)) & 4'($urandom));
      end else begin
        num = 16'($urandom);
        dp  = 4'($urandom);
        @(negedge clk);
      end
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL provide parameter SCAN_DIV, default 100000, clk cycles per digit slot (>= 4).
REQ-003 SHALL provide parameter GUARD, default 16, anti-ghost blank cycles at the start of each slot (0 <= GUARD < SCAN_DIV).
REQ-004 SHALL provide parameter ACTIVE_LOW, default 1; when 1, seg, dp_out and an are active-low.
REQ-005 clk  input  1  system clock; one clock domain; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 num  input  4*DIGITS  hex nibbles; nibble i = num[4i+3:4i] drives digit i; digit 0 is rightmost.
REQ-008 dp  input  DIGITS  decimal point request per digit.
REQ-009 load  input  1  capture num/dp into back buffer this cycle.
REQ-010 blank_lz  input  1  enable leading-zero blanking.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-012 dp_out  output  1  decimal point segment.
REQ-013 an  output  DIGITS  digit enables, one-hot when active.
REQ-014 frame  output  1  one-cycle pulse when the front buffer is updated.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL increment modulo DIGITS (DIGITS-1 -> 0).
REQ-016 load=1 SHALL copy num/dp into back buffer and set a pending flag in the same edge; a later load before commit SHALL overwrite the back buffer.
REQ-017 On the edge where index wraps DIGITS-1 -> 0 with pending set, back SHALL copy to front, pending SHALL clear, and frame SHALL pulse for exactly that following cycle.
REQ-018 load coincident with commit edge SHALL commit the new num/dp (bypass) and leave pending clear.
REQ-019 Display SHALL use only the front buffer; mid-frame load SHALL NOT alter the current frame.
REQ-020 Hex decode SHALL be standard 0-F (0=a..f lit; 1=b,c; 8=all; A,b,C,d,E,F conventional shapes).
REQ-021 With blank_lz=1, digit i>0 SHALL be blanked (seg all off, dp_out off) when front nibbles i..DIGITS-1 are all zero and front dp bits i..DIGITS-1 are all zero; digit 0 never blanked.
REQ-022 During prescaler counts 0..GUARD-1, an SHALL be all off; otherwise an SHALL enable only the current index.
REQ-023 seg, dp_out, an, frame SHALL be registered; outputs SHALL reflect prescaler/index/front state of the previous cycle (1-cycle latency).
REQ-024 Polarity: ACTIVE_LOW=1 -> lit/enabled = 0; ACTIVE_LOW=0 -> lit/enabled = 1.
REQ-025 blank_lz SHALL be sampled every cycle (no buffering).

Reset
REQ-026 rst_n=0 SHALL immediately clear prescaler, index, back, front, pending; an all off, seg all off, dp_out off, frame=0.
REQ-027 Reset mid-frame SHALL discard pending load; after release, display SHALL restart at digit 0 showing 0.
REQ-028 First active slot after release SHALL be digit 0 after GUARD blank cycles.

Verification (DIGITS=4, SCAN_DIV=8, GUARD=2, ACTIVE_LOW=1)
REQ-029 Reset release, no load -> an=1111 for 3 cycles, then an=1110, seg=1000000 for 6 cycles; slot sequence 1110,1101,1011,0111 repeating, 32-cycle period.
REQ-030 load num=16'h12AF mid-frame -> current frame unchanged; frame pulses after index wrap; next frame digit0 seg=0001110 (F), digit3 seg=1111001 (1).
REQ-031 blank_lz=1, num=16'h0050, dp=0 -> digits 3,2 dark (seg=1111111), digit1 shows 5 (0010010), digit0 shows 0; dp=4'b1000 -> digit3 shows 0 with dp_out=0.
REQ-032 load on commit edge with num=16'h0003 -> committed same frame boundary, pending clear, exactly one frame pulse.
REQ-033 Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 displayed; one frame pulse.
REQ-034 rst_n low for 1 cycle mid-slot with pending load -> outputs off asynchronously; after release display 0000, no frame pulse.
